// File: rtl/multiword_sub_pkg.sv
// Shared definitions for the nibble-serial multiword subtractor.
package multiword_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_sub_stage.sv
// Combinational 4-bit subtract stage: {bout, d} = a - b - bin.
import multiword_sub_pkg::*;

module nibble_sub_stage (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout
);

  // A borrow shows up as the wrapped MSB of the one-bit-wider difference.
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, bin};

endmodule

// File: rtl/multiword_sub_ctrl.sv
// Nibble-serial A - B - bin sequencer with valid/ready on both sides.
// Build option: define SUB_SATURATE_EN to clamp diff to 0 when the final borrow is set.
import multiword_sub_pkg::*;

module multiword_sub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
  input  logic                    bin_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] diff,
  output logic                    bout,
  output logic                    busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q;
  logic [W-1:0]       a_q, b_q, diff_q;
  logic [IDX_W-1:0]   idx_q;
  logic               borrow_q, bout_q;
  logic               start_ready_q, res_valid_q, busy_q;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_d;
  logic                nib_bout;

  assign nib_a = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

  nibble_sub_stage u_stage (
    .a    (nib_a),
    .b    (nib_b),
    .bin  (borrow_q),
    .d    (nib_d),
    .bout (nib_bout)
  );

  // NOTE: operand registers carry no reset; they are only consumed after a handshake reloads them.
  always_ff @(posedge clk) begin
    if (start_valid && start_ready_q) begin
      a_q <= op_a;
      b_q <= op_b;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      diff_q        <= '0;
      bout_q        <= 1'b0;
      idx_q         <= '0;
      borrow_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid && start_ready_q) begin
            borrow_q      <= bin_in;
            idx_q         <= '0;
            state_q       <= RUN;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        RUN: begin
          diff_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W] <= nib_d;
          borrow_q <= nib_bout;
          if (idx_q == LAST_IDX) begin
            bout_q      <= nib_bout;
            state_q     <= DONE;
            res_valid_q <= 1'b1;
`ifdef SUB_SATURATE_EN
            if (nib_bout) diff_q <= '0;
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q       <= IDLE;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign diff        = diff_q;
  assign bout        = bout_q;

endmodule

// File: tb/tb_multiword_sub_ctrl.sv
// Directed self-checking bench for multiword_sub_ctrl (NIBBLES=4 and NIBBLES=1 instances).
module tb_multiword_sub_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // NIBBLES = 4 instance
  logic        sv4, sr4, rv4, rr4, bin4, bo4, busy4;
  logic [15:0] a4, b4, d4;
  // NIBBLES = 1 instance
  logic        sv1, sr1, rv1, rr1, bin1, bo1, busy1;
  logic [3:0]  a1, b1, d1;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  logic [15:0] held_diff;
  logic        held_bout;

  multiword_sub_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .op_a(a4), .op_b(b4), .bin_in(bin4), .res_valid(rv4), .res_ready(rr4),
    .diff(d4), .bout(bo4), .busy(busy4)
  );

  multiword_sub_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .op_a(a1), .op_b(b1), .bin_in(bin1), .res_valid(rv1), .res_ready(rr1),
    .diff(d1), .bout(bo1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake on dut4 and wait for res_valid; latency counts edges from the handshake edge.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic bin, output int latency);
    int cnt;
    a4 = a; b4 = b; bin4 = bin; sv4 = 1'b1;
    tick();
    sv4 = 1'b0;
    a4 = ~a; b4 = ~b; bin4 = ~bin;
    cnt = 1;
    while (!rv4 && cnt < 40) begin
      tick();
      cnt++;
    end
    latency = cnt;
  endtask

  task automatic accept4();
    rr4 = 1'b1;
    tick();
    rr4 = 1'b0;
    check("accept_res_valid_low", {31'd0, rv4}, 32'd0);
    check("accept_start_ready", {31'd0, sr4}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    sv4 = 0; rr4 = 0; bin4 = 0; a4 = '0; b4 = '0;
    sv1 = 0; rr1 = 0; bin1 = 0; a1 = '0; b1 = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_start_ready", {31'd0, sr4}, 32'd1);
    check("rst_res_valid", {31'd0, rv4}, 32'd0);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_diff", {16'd0, d4}, 32'd0);
    check("rst_bout", {31'd0, bo4}, 32'd0);
    check("rst1_start_ready", {31'd0, sr1}, 32'd1);

    // 0x1234 - 0x0034, latency 5
    run4(16'h1234, 16'h0034, 1'b0, lat);
    check("v1_latency", lat, 32'd5);
    check("v1_diff", {16'd0, d4}, 32'h1200);
    check("v1_bout", {31'd0, bo4}, 32'd0);
    check("v1_busy", {31'd0, busy4}, 32'd1);
    accept4();
    check("v1_busy_after", {31'd0, busy4}, 32'd0);

    // Borrow ripples through every nibble
    run4(16'h0000, 16'h0001, 1'b0, lat);
`ifdef SUB_SATURATE_EN
    check("v2_diff", {16'd0, d4}, 32'h0000);
`else
    check("v2_diff", {16'd0, d4}, 32'hFFFF);
`endif
    check("v2_bout", {31'd0, bo4}, 32'd1);
    accept4();

    // Equal operands with borrow-in
    run4(16'h5A5A, 16'h5A5A, 1'b1, lat);
`ifdef SUB_SATURATE_EN
    check("v3_diff", {16'd0, d4}, 32'h0000);
`else
    check("v3_diff", {16'd0, d4}, 32'hFFFF);
`endif
    check("v3_bout", {31'd0, bo4}, 32'd1);
    accept4();

    run4(16'h5A5A, 16'h5A5A, 1'b0, lat);
    check("v4_diff", {16'd0, d4}, 32'h0000);
    check("v4_bout", {31'd0, bo4}, 32'd0);
    accept4();

    run4(16'h1000, 16'h0001, 1'b0, lat);
    check("v5_diff", {16'd0, d4}, 32'h0FFF);
    check("v5_bout", {31'd0, bo4}, 32'd0);
    accept4();

    // Hold in DONE with noisy requester
    run4(16'hBEEF, 16'h1234, 1'b0, lat);
    held_diff = d4;
    held_bout = bo4;
    check("hold_diff_initial", {16'd0, d4}, 32'hACBB);
    for (int i = 0; i < 10; i++) begin
      a4 = 16'(i * 16'h1111);
      sv4 = i[0];
      tick();
    end
    check("hold_diff_stable", {16'd0, d4}, {16'd0, held_diff});
    check("hold_bout_stable", {31'd0, bo4}, {31'd0, held_bout});
    check("hold_start_ready", {31'd0, sr4}, 32'd0);
    check("hold_res_valid", {31'd0, rv4}, 32'd1);
    sv4 = 1'b0;
    accept4();

    // Reset mid-RUN at idx=2
    a4 = 16'h0000; b4 = 16'h0001; bin4 = 1'b0; sv4 = 1'b1;
    tick();
    sv4 = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_start_ready", {31'd0, sr4}, 32'd1);
    check("abort_res_valid", {31'd0, rv4}, 32'd0);
    check("abort_diff", {16'd0, d4}, 32'd0);
    check("abort_busy", {31'd0, busy4}, 32'd0);
    tick();
    check("abort_stays_idle", {31'd0, rv4}, 32'd0);
    run4(16'h8765, 16'h4321, 1'b0, lat);
    check("post_abort_latency", lat, 32'd5);
    check("post_abort_diff", {16'd0, d4}, 32'h4444);
    check("post_abort_bout", {31'd0, bo4}, 32'd0);
    accept4();

    // NIBBLES = 1: 3 - 9 wraps to 0xA with borrow, latency 2
    a1 = 4'h3; b1 = 4'h9; bin1 = 1'b0; sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    lat = 1;
    while (!rv1 && lat < 40) begin
      tick();
      lat++;
    end
    check("n1_latency", lat, 32'd2);
`ifdef SUB_SATURATE_EN
    check("n1_diff", {28'd0, d1}, 32'h0);
`else
    check("n1_diff", {28'd0, d1}, 32'hA);
`endif
    check("n1_bout", {31'd0, bo1}, 32'd1);
    rr1 = 1'b1;
    tick();
    rr1 = 1'b0;
    check("n1_start_ready", {31'd0, sr1}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
